// File: rtl/ecc_scrubber_8bit.sv
// ---------------------------------------------------------------------------
// ecc_scrubber_8bit
//
// Background scrubber for the port-B side of the 8-13 soft ECC RAM. While the
// host leaves the port idle, it walks every address and reads back the decoded
// word and its error status. A single-bit (corrected) error is written back
// with the corrected data, so that a second upset cannot turn it into an
// uncorrectable word. Corrected and fatal events are counted, and the
// address of the most recent fatal word is recorded.
//
// Ports
//   i_clk               clock
//   i_rst               synchronous active-high reset
//   i_scrub_en          level; high allows scrubbing
//   i_host_req          host wants the RAM port; scrubber yields
//   o_mem_address       RAM port address (scan pointer)
//   o_mem_wren          RAM port write enable (high only in WB)
//   o_mem_data          RAM write data (corrected word, pre-encode)
//   i_mem_q             decoded RAM read data
//   i_mem_err           [0] no_err, [1] err_corrected, [2] err_fatal
//   o_scrub_active      scrubber owns the port (any state except IDLE/GAP)
//   o_sweep_done        one-cycle pulse when the last address completes
//   o_corrected_count   saturating count of corrected words
//   o_fatal_count       saturating count of fatal words
//   o_fatal_flag        sticky fatal indicator, cleared only by reset
//   o_last_fatal_addr   address of the most recent fatal word
// ---------------------------------------------------------------------------
module ecc_scrubber_8bit #(
    parameter int  NUM_WORDS  = 512,
    parameter int  RD_LATENCY = 4,
    parameter int  GAP_CYCLES = 1024,
    localparam int ADDR_WIDTH = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_scrub_en,
    input  logic                  i_host_req,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic                  o_mem_wren,
    output logic [7:0]            o_mem_data,
    input  logic [7:0]            i_mem_q,
    input  logic [2:0]            i_mem_err,
    output logic                  o_scrub_active,
    output logic                  o_sweep_done,
    output logic [15:0]           o_corrected_count,
    output logic [15:0]           o_fatal_count,
    output logic                  o_fatal_flag,
    output logic [ADDR_WIDTH-1:0] o_last_fatal_addr
);

    localparam int GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int WAIT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_READ,
        S_WAIT,
        S_EVAL,
        S_WB_SETUP,
        S_WB
    } state_t;

    state_t                r_state;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_mem_wren;
    logic [7:0]            r_mem_data;
    logic                  r_scrub_active;
    logic                  r_sweep_done;
    logic [15:0]           r_corrected_count;
    logic [15:0]           r_fatal_count;
    logic                  r_fatal_flag;
    logic [ADDR_WIDTH-1:0] r_last_fatal_addr;

    logic w_err_fatal;
    logic w_err_corr;
    logic w_yield;
    logic w_word_done;

    // Status decode: fatal wins over corrected wins over no_err. An all-zero
    // status is not a legal code from the decoder, so it is treated as fatal.
    assign w_err_fatal = i_mem_err[2] || (i_mem_err == 3'b000);
    assign w_err_corr  = !w_err_fatal && i_mem_err[1];

    // Host activity before the write back is committed abandons the word; the
    // same address is re-read later so a host write is never overwritten with
    // stale data. Once in WB_SETUP the write back always completes.
    assign w_yield = i_host_req &&
                     ((r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_EVAL));

    assign w_word_done = (r_state == S_WB) ||
                         ((r_state == S_EVAL) && !i_host_req && !w_err_corr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= S_IDLE;
            r_gap_cnt         <= '0;
            r_wait_cnt        <= '0;
            r_ptr             <= '0;
            r_mem_wren        <= 1'b0;
            r_mem_data        <= '0;
            r_scrub_active    <= 1'b0;
            r_sweep_done      <= 1'b0;
            r_corrected_count <= '0;
            r_fatal_count     <= '0;
            r_fatal_flag      <= 1'b0;
            r_last_fatal_addr <= '0;
        end else begin
            r_mem_wren   <= 1'b0;
            r_sweep_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_scrub_en && !i_host_req) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (!i_scrub_en) begin
                        r_state <= S_IDLE;
                    end else if (!i_host_req) begin
                        if (r_gap_cnt == GAP_W'(GAP_CYCLES)) begin
                            r_state        <= S_READ;
                            r_scrub_active <= 1'b1;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (!i_host_req) begin
                        if (RD_LATENCY == 1) begin
                            r_state <= S_EVAL;
                        end else begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!i_host_req) begin
                        if (r_wait_cnt == WAIT_W'(WAIT_LAST)) begin
                            r_state <= S_EVAL;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    if (!i_host_req) begin
                        if (w_err_fatal) begin
                            if (r_fatal_count != 16'hFFFF) begin
                                r_fatal_count <= r_fatal_count + 16'd1;
                            end
                            r_fatal_flag      <= 1'b1;
                            r_last_fatal_addr <= r_ptr;
                        end else if (w_err_corr) begin
                            r_mem_data <= i_mem_q;
                            r_state    <= S_WB_SETUP;
                        end
                    end
                end
                S_WB_SETUP: begin
                    // Write data is already stable; the RAM registers it one
                    // cycle ahead of address/wren.
                    r_state    <= S_WB;
                    r_mem_wren <= 1'b1;
                end
                S_WB: begin
                    if (r_corrected_count != 16'hFFFF) begin
                        r_corrected_count <= r_corrected_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_yield) begin
                r_state        <= S_GAP;
                r_gap_cnt      <= '0;
                r_scrub_active <= 1'b0;
            end

            if (w_word_done) begin
                if (r_ptr == LAST_ADDR) begin
                    r_ptr        <= '0;
                    r_sweep_done <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
                r_scrub_active <= 1'b0;
                r_gap_cnt      <= '0;
                r_state        <= i_scrub_en ? S_GAP : S_IDLE;
            end
        end
    end

    assign o_mem_address     = r_ptr;
    assign o_mem_wren        = r_mem_wren;
    assign o_mem_data        = r_mem_data;
    assign o_scrub_active    = r_scrub_active;
    assign o_sweep_done      = r_sweep_done;
    assign o_corrected_count = r_corrected_count;
    assign o_fatal_count     = r_fatal_count;
    assign o_fatal_flag      = r_fatal_flag;
    assign o_last_fatal_addr = r_last_fatal_addr;

endmodule

// File: tb/tb_ecc_scrubber_8bit.sv
// ---------------------------------------------------------------------------
// tb_ecc_scrubber_8bit
//
// Directed test of ecc_scrubber_8bit with 8 words, read latency 4 and no gap.
// A small RAM model returns per-address status/data exactly RD_LATENCY cycles
// after each read and returns an all-zero (invalid) status at any other time.
// A monitor logs read starts, write backs and sweep pulses.
// ---------------------------------------------------------------------------
module tb_ecc_scrubber_8bit;

    localparam int NW  = 8;
    localparam int LAT = 4;
    localparam int GAP = 0;
    localparam int AW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          scrub_en;
    logic          host_req;
    logic [7:0]    mem_q;
    logic [2:0]    mem_err;
    logic [AW-1:0] mem_address;
    logic          mem_wren;
    logic [7:0]    mem_data;
    logic          scrub_active;
    logic          sweep_done;
    logic [15:0]   corrected_count;
    logic [15:0]   fatal_count;
    logic          fatal_flag;
    logic [AW-1:0] last_fatal_addr;

    ecc_scrubber_8bit #(
        .NUM_WORDS  (NW),
        .RD_LATENCY (LAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_scrub_en        (scrub_en),
        .i_host_req        (host_req),
        .o_mem_address     (mem_address),
        .o_mem_wren        (mem_wren),
        .o_mem_data        (mem_data),
        .i_mem_q           (mem_q),
        .i_mem_err         (mem_err),
        .o_scrub_active    (scrub_active),
        .o_sweep_done      (sweep_done),
        .o_corrected_count (corrected_count),
        .o_fatal_count     (fatal_count),
        .o_fatal_flag      (fatal_flag),
        .o_last_fatal_addr (last_fatal_addr)
    );

    // ---------------- RAM model ----------------
    logic [2:0]  err_tab [NW];
    logic [7:0]  q_tab   [NW];
    logic [10:0] pipe    [LAT];
    logic        act_d;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            act_d <= 1'b0;
        end else begin
            // The first active cycle is the READ cycle.
            if (scrub_active && !act_d)
                pipe[0] <= {err_tab[mem_address], q_tab[mem_address]};
            else
                pipe[0] <= '0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            act_d <= scrub_active;
        end
    end

    assign mem_err = pipe[LAT-1][10:8];
    assign mem_q   = pipe[LAT-1][7:0];

    // ---------------- monitor ----------------
    int         rd_q[$];
    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] wr_setup_q[$];
    int         sweep_cnt   = 0;
    int         sweep_reads = 0;
    logic       mon_act_prev  = 1'b0;
    logic [7:0] mon_data_prev = 8'h00;

    always @(posedge clk) begin
        #1;
        if (scrub_active && !mon_act_prev) begin
            rd_q.push_back(int'(mem_address));
            $display("[%0t] read  addr=%0d", $time, mem_address);
        end
        if (mem_wren) begin
            wr_addr_q.push_back(int'(mem_address));
            wr_data_q.push_back(mem_data);
            wr_setup_q.push_back(mon_data_prev);
            $display("[%0t] write addr=%0d data=0x%02h", $time, mem_address, mem_data);
        end
        if (sweep_done) begin
            sweep_cnt   = sweep_cnt + 1;
            sweep_reads = rd_q.size();
            $display("[%0t] sweep_done", $time);
        end
        mon_act_prev  = scrub_active;
        mon_data_prev = mem_data;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int rd_base, wr_base, sw_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_bases();
        rd_base = rd_q.size();
        wr_base = wr_addr_q.size();
        sw_base = sweep_cnt;
    endtask

    task automatic wait_reads(input int n, input string tag);
        int k = 0;
        while ((rd_q.size() - rd_base) < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'((rd_q.size() - rd_base) >= n), 32'd1);
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k = 0;
        while ((wr_addr_q.size() - wr_base) < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'((wr_addr_q.size() - wr_base) >= n), 32'd1);
    endtask

    function automatic int rd_at(input int i);
        return (rd_base + i < rd_q.size()) ? rd_q[rd_base + i] : -1;
    endfunction

    function automatic int wr_addr_at(input int i);
        return (wr_base + i < wr_addr_q.size()) ? wr_addr_q[wr_base + i] : -1;
    endfunction

    function automatic logic [7:0] wr_data_at(input int i);
        return (wr_base + i < wr_data_q.size()) ? wr_data_q[wr_base + i] : 8'hXX;
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_addr"},   32'(mem_address),     32'd0);
        check({pfx, "_wren"},   32'(mem_wren),        32'd0);
        check({pfx, "_data"},   32'(mem_data),        32'd0);
        check({pfx, "_active"}, 32'(scrub_active),    32'd0);
        check({pfx, "_sweep"},  32'(sweep_done),      32'd0);
        check({pfx, "_cc"},     32'(corrected_count), 32'd0);
        check({pfx, "_fc"},     32'(fatal_count),     32'd0);
        check({pfx, "_flag"},   32'(fatal_flag),      32'd0);
        check({pfx, "_lfa"},    32'(last_fatal_addr), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b1;
        scrub_en = 1'b0;
        host_req = 1'b0;
        for (int i = 0; i < NW; i++) begin
            err_tab[i] = 3'b001;
            q_tab[i]   = 8'(i * 17);
        end
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;

        // Clean sweep: 0..7 in order, one sweep pulse, then addr 0 again.
        set_bases();
        scrub_en = 1'b1;
        wait_reads(9, "t1_reads_timeout");
        scrub_en = 1'b0;
        for (int i = 0; i < 9; i++)
            check($sformatf("t1_rd%0d", i), 32'(rd_at(i)), 32'(i % NW));
        check("t1_sweep_cnt", 32'(sweep_cnt - sw_base), 32'd1);
        check("t1_sweep_pos", 32'(sweep_reads - rd_base), 32'd8);
        idle(12);
        check("t1_no_wren", 32'(wr_addr_q.size() - wr_base), 32'd0);
        check("t1_cc", 32'(corrected_count), 32'd0);
        check("t1_fc", 32'(fatal_count), 32'd0);

        // Correctable word at addr 3 (scan resumes at 1).
        err_tab[3] = 3'b010;
        q_tab[3]   = 8'hA5;
        set_bases();
        scrub_en = 1'b1;
        wait_reads(4, "t2_reads_timeout");
        scrub_en = 1'b0;
        idle(12);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_rd%0d", i), 32'(rd_at(i)), 32'(i + 1));
        check("t2_nwr", 32'(wr_addr_q.size() - wr_base), 32'd1);
        check("t2_wr_addr", 32'(wr_addr_at(0)), 32'd3);
        check("t2_wr_data", 32'(wr_data_at(0)), 32'hA5);
        check("t2_setup_data", 32'((wr_base < wr_setup_q.size()) ? wr_setup_q[wr_base] : 8'h00), 32'hA5);
        check("t2_data_hold", 32'(mem_data), 32'hA5);
        check("t2_cc", 32'(corrected_count), 32'd1);
        check("t2_wren_low", 32'(mem_wren), 32'd0);
        err_tab[3] = 3'b001;

        // Fatal words at 5 and 6 (scan resumes at 5).
        err_tab[5] = 3'b100;
        err_tab[6] = 3'b100;
        set_bases();
        scrub_en = 1'b1;
        wait_reads(2, "t3_reads_timeout_a");
        check("t3_fc1", 32'(fatal_count), 32'd1);
        check("t3_flag1", 32'(fatal_flag), 32'd1);
        check("t3_lfa1", 32'(last_fatal_addr), 32'd5);
        wait_reads(3, "t3_reads_timeout_b");
        scrub_en = 1'b0;
        check("t3_fc2", 32'(fatal_count), 32'd2);
        check("t3_lfa2", 32'(last_fatal_addr), 32'd6);
        idle(12);
        check("t3_first_rd", 32'(rd_at(0)), 32'd5);
        check("t3_no_wren", 32'(wr_addr_q.size() - wr_base), 32'd0);
        check("t3_flag_sticky", 32'(fatal_flag), 32'd1);
        err_tab[5] = 3'b001;
        err_tab[6] = 3'b001;

        // Host race on a corrected word at addr 2 (scan resumes at 0).
        err_tab[2] = 3'b010;
        q_tab[2]   = 8'h3C;
        set_bases();
        scrub_en = 1'b1;
        wait_reads(3, "t4_reads_timeout_a");
        idle(2);
        host_req = 1'b1;
        @(negedge clk);
        check("t4_yield_active", 32'(scrub_active), 32'd0);
        idle(6);
        check("t4_no_wr_during_host", 32'(wr_addr_q.size() - wr_base), 32'd0);
        check("t4_hold_reads", 32'(rd_q.size() - rd_base), 32'd3);
        host_req = 1'b0;
        wait_writes(1, "t4_wr_timeout");
        wait_reads(5, "t4_reads_timeout_b");
        scrub_en = 1'b0;
        idle(12);
        check("t4_rd2", 32'(rd_at(2)), 32'd2);
        check("t4_reread", 32'(rd_at(3)), 32'd2);
        check("t4_rd_next", 32'(rd_at(4)), 32'd3);
        check("t4_nwr", 32'(wr_addr_q.size() - wr_base), 32'd1);
        check("t4_wr_addr", 32'(wr_addr_at(0)), 32'd2);
        check("t4_wr_data", 32'(wr_data_at(0)), 32'h3C);
        check("t4_cc", 32'(corrected_count), 32'd2);
        err_tab[2] = 3'b001;

        // Saturation from 0xFFFE, plus invalid status 000 at addr 7.
        force dut.r_corrected_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_corrected_count;
        @(negedge clk);
        check("t5_preload", 32'(corrected_count), 32'hFFFE);
        for (int i = 4; i < 7; i++) begin
            err_tab[i] = 3'b010;
            q_tab[i]   = 8'(8'h11 * (i - 3));
        end
        err_tab[7] = 3'b000;
        set_bases();
        scrub_en = 1'b1;
        wait_reads(5, "t5_reads_timeout");
        scrub_en = 1'b0;
        idle(12);
        check("t5_nwr", 32'(wr_addr_q.size() - wr_base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_wr_addr%0d", i), 32'(wr_addr_at(i)), 32'(i + 4));
            check($sformatf("t5_wr_data%0d", i), 32'(wr_data_at(i)), 32'(8'h11 * (i + 1)));
        end
        check("t5_cc_sat", 32'(corrected_count), 32'hFFFF);
        check("t5_fc_invalid", 32'(fatal_count), 32'd3);
        check("t5_lfa_invalid", 32'(last_fatal_addr), 32'd7);
        for (int i = 4; i < 8; i++) err_tab[i] = 3'b001;

        // Disable during WAIT on a corrected word at addr 1.
        err_tab[1] = 3'b010;
        q_tab[1]   = 8'h5A;
        set_bases();
        scrub_en = 1'b1;
        wait_reads(1, "t6_reads_timeout");
        idle(2);
        scrub_en = 1'b0;
        idle(20);
        check("t6_nwr", 32'(wr_addr_q.size() - wr_base), 32'd1);
        check("t6_wr_addr", 32'(wr_addr_at(0)), 32'd1);
        check("t6_wr_data", 32'(wr_data_at(0)), 32'h5A);
        check("t6_nrd", 32'(rd_q.size() - rd_base), 32'd1);
        check("t6_idle", 32'(scrub_active), 32'd0);
        check("t6_cc_sat", 32'(corrected_count), 32'hFFFF);
        err_tab[1] = 3'b001;

        // Reset during WB on a corrected word at addr 2.
        err_tab[2] = 3'b010;
        q_tab[2]   = 8'h77;
        set_bases();
        scrub_en = 1'b1;
        begin
            int k = 0;
            while (!mem_wren && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check("t7_wb_seen", 32'(mem_wren), 32'd1);
        check("t7_wb_addr", 32'(mem_address), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t7_rst");
        rst = 1'b0;
        err_tab[2] = 3'b001;
        set_bases();
        wait_reads(1, "t7_reads_timeout");
        check("t7_rescan_addr", 32'(rd_at(0)), 32'd0);
        scrub_en = 1'b0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
